// File: rtl/posit_defines.sv
// Shared widths, constants and the raw sum record for the ES=2 posit datapath.
package posit_defines;

  // Fraction bits carried by the raw sum format (hidden bit excluded).
  localparam int ABITS = 30;

  // Raw sum, MSB first: sgn, scale[7:0], fraction[ABITS-1:0], inf, zero.
  localparam int POSIT_SERIALIZED_WIDTH_SUM_ES2 = 1 + 8 + ABITS + 1 + 1;

  localparam int          POSIT_WIDTH_ES2     = 32;
  localparam logic [31:0] POSIT_NAR_ES2       = 32'h8000_0000;
  localparam int          POSIT_MAX_SCALE_ES2 = 120;

  typedef struct packed {
    logic                    sgn;
    logic signed [7:0]       scale;
    logic [ABITS-1:0]        fraction;
    logic                    inf;
    logic                    zero;
  } value_sum;

endpackage

// File: rtl/shift_right.sv
// Logical right shifter, zero fill.
module shift_right #(
  parameter int N = 64,
  parameter int S = 6
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] shamt,
  output logic [N-1:0] y
);

  assign y = a >> shamt;

endmodule

// File: rtl/posit_encode_4_raw.sv
// Raw ES=2 sum -> packed posit<32,2> encoder, latency 3 cycles, 1 op/cycle.
// Build option: define POSIT_ENCODE_RNE_EN for round-to-nearest-even;
// otherwise the magnitude is truncated (still clamped up to minpos).
module posit_encode_4_raw
  import posit_defines::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] in,
  input  logic                                      start,
  output logic [POSIT_WIDTH_ES2-1:0]                result,
  output logic                                      done
);

  localparam int SH_N     = 64;
  localparam int SH_S     = 6;
  localparam int BODY_PAD = SH_N - 3 - ABITS;

  localparam logic signed [7:0] SCALE_MAX  = 8'(POSIT_MAX_SCALE_ES2);
  localparam logic signed [7:0] SCALE_MIN  = -SCALE_MAX;
  localparam logic [30:0]       MAXPOS_MAG = 31'h7FFF_FFFF;
  localparam logic [30:0]       MINPOS_MAG = 31'h0000_0001;

  function automatic logic signed [7:0] sat_scale(input logic signed [7:0] s);
    if (s > SCALE_MAX) return SCALE_MAX;
    if (s < SCALE_MIN) return SCALE_MIN;
    return s;
  endfunction

`ifdef POSIT_ENCODE_RNE_EN
  // Nearest-even on the 31-bit magnitude; never carries into the sign bit
  // and never collapses a nonzero value to zero.
  function automatic logic [30:0] round_mag(input logic [30:0] mag,
                                            input logic        guard,
                                            input logic        sticky);
    logic [31:0] sum;
    sum = {1'b0, mag} + {31'd0, guard & (sticky | mag[0])};
    if (sum[31]) return MAXPOS_MAG;
    if (sum[30:0] == 31'd0) return MINPOS_MAG;
    return sum[30:0];
  endfunction
`else
  // Truncation: dropped bits are discarded, a zero magnitude becomes minpos.
  function automatic logic [30:0] round_mag(input logic [30:0] mag);
    if (mag == 31'd0) return MINPOS_MAG;
    return mag;
  endfunction
`endif

  function automatic logic [31:0] apply_sign(input logic sgn, input logic [30:0] mag);
    if (sgn) return ~{1'b0, mag} + 32'd1;
    return {1'b0, mag};
  endfunction

  // ---------------- stage 0: input capture and decode ----------------
  value_sum in_p0;
  logic     vld_p0;

  logic signed [7:0]  scale_s0;
  logic signed [7:0]  scale_c_s0;
  logic signed [5:0]  k_s0;
  logic               sat_hi_s0;
  logic               sat_lo_s0;
  logic               fill_s0;
  logic [SH_S-1:0]    run_s0;
  logic [SH_N-1:0]    body_s0;

  assign scale_s0   = in_p0.scale;
  assign scale_c_s0 = sat_scale(scale_s0);
  assign sat_hi_s0  = (scale_s0 >= SCALE_MAX);
  assign sat_lo_s0  = (scale_s0 <= SCALE_MIN);
  // k = scale >>> 2 is simply the upper six bits of the clamped scale.
  assign k_s0       = scale_c_s0[7:2];
  // Regime run bit: ones for k >= 0, zeros for k < 0.
  assign fill_s0    = ~k_s0[5];
  assign run_s0     = fill_s0 ? 6'(k_s0 + 6'sd1) : 6'(-k_s0);
  // Terminating regime bit, exponent, fraction, left-aligned; the run is
  // shifted in above it by stage 1.
  assign body_s0    = {~fill_s0, scale_c_s0[1:0], in_p0.fraction, {BODY_PAD{1'b0}}};

  // ---------------- stage 1: regime placement ----------------
  logic            sgn_p1, inf_p1, zero_p1, sat_hi_p1, sat_lo_p1, fill_p1;
  logic [SH_S-1:0] run_p1;
  logic [SH_N-1:0] body_p1;
  logic            vld_p1;

  logic [SH_N-1:0] shift_in_s1;
  logic [SH_N-1:0] shift_out_s1;
  logic [SH_N-1:0] placed_s1;

  // Shifting the inverted word with zero fill and inverting back yields a
  // ones-filled shift, so one logical shifter covers both regime polarities.
  assign shift_in_s1 = body_p1 ^ {SH_N{fill_p1}};

  shift_right #(
    .N(SH_N),
    .S(SH_S)
  ) u_regime_shift (
    .a    (shift_in_s1),
    .shamt(run_p1),
    .y    (shift_out_s1)
  );

  assign placed_s1 = shift_out_s1 ^ {SH_N{fill_p1}};

  // ---------------- stage 2: round, saturate, sign, specials ----------------
  logic        sgn_p2, inf_p2, zero_p2, sat_hi_p2, sat_lo_p2;
  logic [30:0] mag_p2;
  logic        vld_p2;
`ifdef POSIT_ENCODE_RNE_EN
  logic        guard_p2;
  logic        sticky_p2;
`else
  logic        unused_tail_s1;
  assign unused_tail_s1 = ^placed_s1[32:0];
`endif

  logic [30:0] mag_s2;
  logic [31:0] result_s2;

  // Valid pipeline and done strobe; an X on start is taken as no request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (start) vld_p0 <= 1'b1;
      else       vld_p0 <= 1'b0;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      done   <= vld_p2;
    end
  end

  // Data registers load every cycle; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    in_p0     <= in;

    sgn_p1    <= in_p0.sgn;
    inf_p1    <= in_p0.inf;
    zero_p1   <= in_p0.zero;
    sat_hi_p1 <= sat_hi_s0;
    sat_lo_p1 <= sat_lo_s0;
    fill_p1   <= fill_s0;
    run_p1    <= run_s0;
    body_p1   <= body_s0;

    sgn_p2    <= sgn_p1;
    inf_p2    <= inf_p1;
    zero_p2   <= zero_p1;
    sat_hi_p2 <= sat_hi_p1;
    sat_lo_p2 <= sat_lo_p1;
    mag_p2    <= placed_s1[63:33];
`ifdef POSIT_ENCODE_RNE_EN
    guard_p2  <= placed_s1[32];
    sticky_p2 <= |placed_s1[31:0];
`endif
  end

  // Final word: specials first, then saturated scales, then rounded body.
  always_comb begin
    mag_s2    = MAXPOS_MAG;
    result_s2 = 32'd0;
    if (sat_hi_p2)      mag_s2 = MAXPOS_MAG;
    else if (sat_lo_p2) mag_s2 = MINPOS_MAG;
    else begin
`ifdef POSIT_ENCODE_RNE_EN
      mag_s2 = round_mag(mag_p2, guard_p2, sticky_p2);
`else
      mag_s2 = round_mag(mag_p2);
`endif
    end
    if (inf_p2)       result_s2 = POSIT_NAR_ES2;
    else if (zero_p2) result_s2 = 32'd0;
    else              result_s2 = apply_sign(sgn_p2, mag_s2);
  end

  // Output register holds its value between valid results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       result <= '0;
    else if (vld_p2) result <= result_s2;
  end

endmodule

// File: tb/tb_posit_encode_4_raw.sv
// Directed, table-driven bench for posit_encode_4_raw (either rounding build).
module tb_posit_encode_4_raw;
  import posit_defines::*;

`ifdef POSIT_ENCODE_RNE_EN
  localparam bit RNE_BUILD = 1'b1;
`else
  localparam bit RNE_BUILD = 1'b0;
`endif

  localparam int NV = 20;
  localparam logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] IDLE_PAT = 41'h0AA_AAAA_AAAA;

  typedef struct {
    logic              sgn;
    logic signed [7:0] scale;
    logic [29:0]       frac;
    logic              inf;
    logic              zero;
    logic [31:0]       exp_rne;
    logic [31:0]       exp_trn;
  } vec_t;

  logic                                      clk;
  logic                                      reset;
  logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] din;
  logic                                      start;
  logic [31:0]                               result;
  logic                                      done;

  vec_t        vecs[NV];
  logic        sv[4];
  int          si[4];
  logic [31:0] last_res;
  int          checks;
  int          failures;

  posit_encode_4_raw dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .start (start),
    .result(result),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] pack(input vec_t v);
    return {v.sgn, v.scale, v.frac, v.inf, v.zero};
  endfunction

  function automatic logic [31:0] exp_of(input int idx);
    return RNE_BUILD ? vecs[idx].exp_rne : vecs[idx].exp_trn;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // One clock: drive before the edge, then check the output after it.
  task automatic cycle(input bit st, input int idx);
    start = st;
    din   = st ? pack(vecs[idx]) : IDLE_PAT;
    @(posedge clk);
    for (int s = 3; s > 0; s--) begin
      sv[s] = sv[s-1];
      si[s] = si[s-1];
    end
    sv[0] = st;
    si[0] = idx;
    @(negedge clk);
    chk($sformatf("done t=%0t", $time), {31'd0, done}, {31'd0, sv[3]});
    if (sv[3]) begin
      chk($sformatf("vec%0d result", si[3]), result, exp_of(si[3]));
      last_res = exp_of(si[3]);
    end else begin
      chk($sformatf("hold t=%0t", $time), result, last_res);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_res = 32'd0;
    for (int s = 0; s < 4; s++) begin
      sv[s] = 1'b0;
      si[s] = 0;
    end
    reset = 1'b1;
    start = 1'b0;
    din   = '0;

    //           sgn  scale      frac            inf   zero  rne           trunc
    vecs[0]  = '{1'b0, 8'sd0,    30'h0,          1'b0, 1'b0, 32'h4000_0000, 32'h4000_0000};
    vecs[1]  = '{1'b1, 8'sd0,    30'h0,          1'b0, 1'b0, 32'hC000_0000, 32'hC000_0000};
    vecs[2]  = '{1'b0, 8'sd1,    30'h0,          1'b0, 1'b0, 32'h4800_0000, 32'h4800_0000};
    vecs[3]  = '{1'b0, 8'sd0,    30'h2000_0000,  1'b0, 1'b0, 32'h4400_0000, 32'h4400_0000};
    vecs[4]  = '{1'b0, 8'sd16,   30'h0,          1'b0, 1'b0, 32'h7C00_0000, 32'h7C00_0000};
    vecs[5]  = '{1'b1, -8'sd77,  30'h2AAA_5555,  1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000};
    vecs[6]  = '{1'b1, 8'sd33,   30'h0123_4567,  1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{1'b0, 8'sd127,  30'h0,          1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[8]  = '{1'b0, -8'sd128, 30'h0,          1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001};
    vecs[9]  = '{1'b0, 8'sd0,    30'h0000_0004,  1'b0, 1'b0, 32'h4000_0000, 32'h4000_0000};
    vecs[10] = '{1'b0, 8'sd0,    30'h0000_0005,  1'b0, 1'b0, 32'h4000_0001, 32'h4000_0000};
    vecs[11] = '{1'b0, 8'sd119,  30'h3FFF_FFFF,  1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFE};
    vecs[12] = '{1'b0, -8'sd119, 30'h0,          1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001};
    vecs[13] = '{1'b0, -8'sd1,   30'h0,          1'b0, 1'b0, 32'h3800_0000, 32'h3800_0000};
    vecs[14] = '{1'b0, -8'sd5,   30'h0,          1'b0, 1'b0, 32'h1C00_0000, 32'h1C00_0000};
    vecs[15] = '{1'b1, 8'sd127,  30'h0,          1'b0, 1'b0, 32'h8000_0001, 32'h8000_0001};
    vecs[16] = '{1'b1, -8'sd128, 30'h0,          1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[17] = '{1'b1, 8'sd1,    30'h0,          1'b0, 1'b0, 32'hB800_0000, 32'hB800_0000};
    vecs[18] = '{1'b0, 8'sd0,    30'h0000_000C,  1'b0, 1'b0, 32'h4000_0002, 32'h4000_0001};
    vecs[19] = '{1'b0, 8'sd5,    30'h0000_0003,  1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    reset = 1'b0;

    // All vectors back to back, then drain.
    for (int i = 0; i < NV; i++) cycle(1'b1, i);
    repeat (4) cycle(1'b0, 0);

    // Same vectors with an idle cycle between each.
    for (int i = NV - 1; i >= 0; i--) begin
      cycle(1'b1, i);
      cycle(1'b0, 0);
    end
    repeat (4) cycle(1'b0, 0);

    // Reset with one result showing and two operands in flight.
    cycle(1'b1, 2);
    cycle(1'b1, 3);
    cycle(1'b1, 4);
    cycle(1'b0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async reset done", {31'd0, done}, 32'd0);
    chk("async reset result", result, 32'd0);
    for (int s = 0; s < 4; s++) sv[s] = 1'b0;
    last_res = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    // Start on the first cycle after release; the dropped operands must not appear.
    cycle(1'b1, 17);
    repeat (5) cycle(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_encode_4_raw.md
# posit_encode_4_raw

Pipelined encoder converting the raw serialized sum format of the ES=2 posit datapath (sign, scale, fraction, inf, zero) into a packed 32-bit posit with es=2. It sits directly after the four-stage raw adder and the other raw-format arithmetic units, forming the write-back end of the raw protocol. It accepts one operand per cycle with a start/done strobe pair and no back-pressure.

## Interface
- No parameters; all widths come from `posit_defines`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in`  in  POSIT_SERIALIZED_WIDTH_SUM_ES2  raw sum, MSB first: sgn, scale (8-bit signed), fraction (ABITS bits, hidden bit excluded), inf, zero (bit 0)
- `start`  in  1  `in` is valid this cycle
- `result`  out  32  packed posit<32,2>
- `done`  out  1  `result` is valid this cycle

## Operation
- Priority of specials: `inf`=1 gives NaR (0x80000000). Otherwise `zero`=1 gives 0x00000000. Sign, scale and fraction are ignored in both cases.
- Scale saturation: scale is clamped to [-120, +120].
  - +120 encodes maxpos 0x7FFFFFFF; -120 encodes minpos 0x00000001.
  - Clamped values bypass rounding.
- Regime: k = scale >>> 2 (arithmetic shift); exponent = scale[1:0].
  - k ≥ 0: (k+1) ones followed by a zero.
  - k < 0: (-k) zeros followed by a one.
- Body: the word {regime, exponent, fraction} is left-aligned at bit 30 and right-shifted by the regime length. Bits below bit 0 form the guard bit (first dropped bit) and the sticky bit (OR of the rest).
- Rounding: round to nearest, ties to even, applied on the 31-bit magnitude.
  - A rounded nonzero magnitude never becomes 0; the result is clamped to 0x00000001.
  - Rounding never carries into bit 31; the result is clamped to 0x7FFFFFFF.
- Sign: when sgn=1, result = two's complement of {0, magnitude}.
- An X on `start` is treated as 0.

## Timing
- Three register stages; latency is exactly 3 cycles. `in`/`start` sampled at edge N give `result`/`done` valid after edge N+3.
- Throughput is 1 per cycle. Back-to-back starts give back-to-back dones in order.
- S0: register the input; decode specials; clamp the scale; compute k, exponent and regime length.
- S1: place the regime and shift; extract guard/sticky; carry the special flags and sign forward.
- S2: round, saturate, negate, select specials; register `result` and `done`.
- Each stage carries a valid bit that advances every cycle. Data registers load unconditionally.
- `result` holds its value while `done`=0. No hold requirement applies to the consumer.
- Reset: all valid bits, `done` and `result` go to 0 immediately (asynchronous). In-flight operands are dropped and produce no `done`.
- A `start` in the cycle reset deasserts is sampled normally.

## Configuration
- `POSIT_ENCODE_RNE_EN` defined: round-to-nearest-even as described above.
- Undefined: truncation. Guard and sticky are ignored, except that a nonzero magnitude still clamps to minpos.
- Latency and stage count are unchanged in both builds.

## Structure
- `posit_defines` gains:
  - `POSIT_WIDTH_ES2` = 32
  - `POSIT_NAR_ES2` = 32'h80000000
  - `POSIT_MAX_SCALE_ES2` = 120
- Reuse the existing `value_sum` typedef and `ABITS` to unpack `in`.
- One sub-module: reuse existing `shift_right` (N=64, S=6) for regime placement. Rounding stays inline.

## Test plan
- Scale 0, fraction 0, sgn 0 -> 0x40000000. Same with sgn 1 -> 0xC0000000. Scale 1 -> 0x48000000. Scale 0 with fraction MSB set -> 0x44000000. Scale 16 -> 0x7C000000.
- inf=1 with zero=1 and garbage fields -> 0x80000000. zero=1 alone -> 0x00000000. Scale +127 -> 0x7FFFFFFF. Scale -128 -> 0x00000001.
- Scale 0, fraction with only the bit below the 27th fraction bit set (exact tie) -> 0x40000000. Same plus one lower bit set -> 0x40000001 with the macro defined, 0x40000000 with it undefined.
- Largest fraction at scale +119 that rounds up -> 0x7FFFFFFF, never 0x80000000. Smallest positive below minpos -> 0x00000001.
- Start pulses on 8 consecutive cycles with distinct operands -> 8 consecutive dones starting at edge 3, correct and in order. Idle gaps give `done`=0.
- Assert reset with 2 operands in flight -> `done`/`result` go to 0 immediately and no done appears after release. A start on the first post-reset cycle completes 3 cycles later.
